// File: rtl/medikit_lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : medikit_lcd_pkg
//  Description : Shared FSM encoding, LCD1602 character codes and the helper
//                that turns one BCD value into a tens/units character pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package medikit_lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNAP   = 3'd1,
    ST_CONV   = 3'd2,
    ST_STORE  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_DASH  = 8'h2D;
  localparam logic [7:0] CHAR_BLANK = 8'hA0;
  localparam int         NUM_VALS   = 6;
  localparam int         NUM_CHARS  = 2 * NUM_VALS;

  // Returns {tens_char, units_char}. Anything of 100 or more cannot fit in
  // two digits, so it is shown as "--" rather than a truncated number.
  function automatic logic [15:0] encode_pair(
    input logic [1:0] hund,
    input logic [3:0] tens,
    input logic [3:0] units,
    input logic       lead_blank,
    input logic [7:0] blank_code
  );
    logic [7:0] tens_c;
    logic [7:0] units_c;
    if (hund != 2'd0) begin
      tens_c  = CHAR_DASH;
      units_c = CHAR_DASH;
    end else begin
      units_c = CHAR_ZERO + {4'h0, units};
      if (tens == 4'd0 && lead_blank)
        tens_c = blank_code;
      else
        tens_c = CHAR_ZERO + {4'h0, tens};
    end
    return {tens_c, units_c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_digit_encoder_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : 7-bit binary to BCD, shift-add-3, one bit per clock.
//                load_i captures a value; seven shift cycles follow; valid_o
//                pulses for one cycle once the digits are final.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       load_i,
  input  logic [6:0] bin_i,
  output logic       last_o,
  output logic       valid_o,
  output logic [1:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  logic [6:0] bin_q;
  logic [9:0] bcd_q;
  logic [2:0] cnt_q;
  logic       active_q;
  logic       valid_q;
  logic [8:0] adj_d;

  // Add-3 correction on any BCD digit of 5 or more before it is doubled.
  // The hundreds digit never exceeds 1 for a 7-bit input, so it needs none.
  always_comb begin
    adj_d = bcd_q[8:0];
    if (bcd_q[3:0] >= 4'd5) adj_d[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) adj_d[7:4] = bcd_q[7:4] + 4'd3;
  end

  // Load, then shift one binary bit into the BCD field per cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bin_q    <= 7'd0;
      bcd_q    <= 10'd0;
      cnt_q    <= 3'd0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (load_i) begin
      bin_q    <= bin_i;
      bcd_q    <= 10'd0;
      cnt_q    <= 3'd0;
      active_q <= 1'b1;
      valid_q  <= 1'b0;
    end else if (active_q) begin
      {bcd_q, bin_q} <= {adj_d, bin_q, 1'b0};
      cnt_q          <= cnt_q + 3'd1;
      if (cnt_q == 3'd6) begin
        active_q <= 1'b0;
        valid_q  <= 1'b1;
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign last_o  = active_q && (cnt_q == 3'd6);
  assign valid_o = valid_q;
  assign hund_o  = bcd_q[9:8];
  assign tens_o  = bcd_q[7:4];
  assign units_o = bcd_q[3:0];

endmodule
`default_nettype wire

// File: rtl/lcd_digit_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_digit_encoder
//  Description : Snapshots six 7-bit values, converts each to a tens/units
//                LCD1602 character pair and commits all twelve codes on one
//                edge so the display never sees a half-updated frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_digit_encoder
  import medikit_lcd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000000,
  parameter bit          LEAD_BLANK  = 1'b1,
  parameter logic [7:0]  BLANK_CODE  = CHAR_BLANK
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [6:0] VAL0,
  input  logic [6:0] VAL1,
  input  logic [6:0] VAL2,
  input  logic [6:0] VAL3,
  input  logic [6:0] VAL4,
  input  logic [6:0] VAL5,
  output logic [7:0] YIMA_DATA1,
  output logic [7:0] YIMA_DATA2,
  output logic [7:0] YIMA_DATA3,
  output logic [7:0] YIMA_DATA4,
  output logic [7:0] YIMA_DATA5,
  output logic [7:0] YIMA_DATA6,
  output logic [7:0] YIMA_DATA7,
  output logic [7:0] YIMA_DATA8,
  output logic [7:0] YIMA_DATA9,
  output logic [7:0] YIMA_DATA10,
  output logic [7:0] YIMA_DATA11,
  output logic [7:0] YIMA_DATA12,
  output logic       Busy,
  output logic       Done
);

  state_e     state_q;
  logic [2:0] idx_q;
  logic       pending_q;
  logic       done_q;
  logic [6:0] snap_q   [NUM_VALS];
  logic [7:0] shadow_q [NUM_CHARS];
  logic [7:0] data_q   [NUM_CHARS];

  logic        tick;
  logic        trigger;
  logic        load_d;
  logic [6:0]  load_val_d;
  logic [2:0]  next_idx_d;
  logic        conv_last;
  logic        conv_valid;
  logic [1:0]  conv_hund;
  logic [3:0]  conv_tens;
  logic [3:0]  conv_units;
  logic [15:0] pair_d;

  // Free-running refresh timer; it keeps counting while a conversion runs.
  generate
    if (REFRESH_DIV == 0) begin : g_no_refresh
      assign tick = 1'b0;
    end else begin : g_refresh
      logic [31:0] refresh_cnt_q;
      always_ff @(posedge Clk) begin
        if (Rst)
          refresh_cnt_q <= 32'd0;
        else if (refresh_cnt_q == REFRESH_DIV - 1)
          refresh_cnt_q <= 32'd0;
        else
          refresh_cnt_q <= refresh_cnt_q + 32'd1;
      end
      assign tick = (refresh_cnt_q == REFRESH_DIV - 1);
    end
  endgenerate

  assign trigger = Start | tick;

  // Next converter operand: VAL0 straight from the port while snapping (the
  // snapshot is written on the same edge), otherwise the next snapshot slot.
  always_comb begin
    next_idx_d = idx_q + 3'd1;
    load_d     = (state_q == ST_SNAP) ||
                 ((state_q == ST_STORE) && (idx_q != 3'(NUM_VALS - 1)));
    load_val_d = VAL0;
    if (state_q == ST_STORE && idx_q < 3'(NUM_VALS - 1))
      load_val_d = snap_q[next_idx_d];
  end

  bin2bcd_seq u_bin2bcd (
    .Clk     (Clk),
    .Rst     (Rst),
    .load_i  (load_d),
    .bin_i   (load_val_d),
    .last_o  (conv_last),
    .valid_o (conv_valid),
    .hund_o  (conv_hund),
    .tens_o  (conv_tens),
    .units_o (conv_units)
  );

  assign pair_d = encode_pair(conv_hund, conv_tens, conv_units, LEAD_BLANK, BLANK_CODE);

  // Sequencer: snapshot, six conversions into the shadow, single-edge commit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_VALS; i++)  snap_q[i]   <= 7'd0;
      for (int i = 0; i < NUM_CHARS; i++) shadow_q[i] <= BLANK_CODE;
      for (int i = 0; i < NUM_CHARS; i++) data_q[i]   <= BLANK_CODE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trigger) state_q <= ST_SNAP;
        end
        ST_SNAP: begin
          snap_q[0] <= VAL0;
          snap_q[1] <= VAL1;
          snap_q[2] <= VAL2;
          snap_q[3] <= VAL3;
          snap_q[4] <= VAL4;
          snap_q[5] <= VAL5;
          idx_q     <= 3'd0;
          // This run serves any earlier request; only a new one re-arms.
          pending_q <= trigger;
          state_q   <= ST_CONV;
        end
        ST_CONV: begin
          if (trigger) pending_q <= 1'b1;
          if (conv_last) state_q <= ST_STORE;
        end
        ST_STORE: begin
          if (trigger) pending_q <= 1'b1;
          if (conv_valid) begin
            shadow_q[{idx_q, 1'b0}] <= pair_d[15:8];
            shadow_q[{idx_q, 1'b1}] <= pair_d[7:0];
          end
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'(NUM_VALS - 1))
            state_q <= ST_COMMIT;
          else
            state_q <= ST_CONV;
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_CHARS; i++) data_q[i] <= shadow_q[i];
          done_q    <= 1'b1;
          pending_q <= pending_q | trigger;
          if (pending_q || trigger)
            state_q <= ST_SNAP;
          else
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Busy        = (state_q != ST_IDLE);
  assign Done        = done_q;
  assign YIMA_DATA1  = data_q[0];
  assign YIMA_DATA2  = data_q[1];
  assign YIMA_DATA3  = data_q[2];
  assign YIMA_DATA4  = data_q[3];
  assign YIMA_DATA5  = data_q[4];
  assign YIMA_DATA6  = data_q[5];
  assign YIMA_DATA7  = data_q[6];
  assign YIMA_DATA8  = data_q[7];
  assign YIMA_DATA9  = data_q[8];
  assign YIMA_DATA10 = data_q[9];
  assign YIMA_DATA11 = data_q[10];
  assign YIMA_DATA12 = data_q[11];

endmodule
`default_nettype wire

// File: tb/tb_lcd_digit_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_digit_encoder
//  Description : Scoreboard bench for lcd_digit_encoder. Three instances:
//                default parameters, LEAD_BLANK=0, and REFRESH_DIV=64.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_digit_encoder;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst, rst_r, Start, start_r;
  logic [6:0] v  [6];
  logic [6:0] vr [6];
  logic [7:0] d_m [12];
  logic [7:0] d_l [12];
  logic [7:0] d_r [12];
  logic       busy_m, done_m, busy_l, done_l, busy_r, done_r;
  logic [95:0] out_m, out_l, out_r;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  logic [95:0] q_m [$];
  int          qc_m [$];
  logic [95:0] q_l [$];
  int          done_cnt_m = 0;
  int          ref_cnt = 0;
  int          ref_last = -1;
  int          stable_viol = 0;
  logic        ref_committed = 1'b0;
  logic [95:0] ref_prev;

  localparam logic [95:0] ALL_BLANK = {12{8'hA0}};
  localparam logic [95:0] E1  = 96'h3432_A037_A030_3939_3130_A035;
  localparam logic [95:0] L1  = 96'h3432_3037_3030_3939_3130_3035;
  localparam logic [95:0] E2  = 96'h3535_A037_A030_3939_3130_A035;
  localparam logic [95:0] L2  = 96'h3535_3037_3030_3939_3130_3035;
  localparam logic [95:0] E3  = 96'h2D2D_2D2D_A039_3530_A031_3830;
  localparam logic [95:0] L3  = 96'h2D2D_2D2D_3039_3530_3031_3830;
  localparam logic [95:0] E4  = 96'h3139_3230_3634_3333_A035_A030;
  localparam logic [95:0] L4  = 96'h3139_3230_3634_3333_3035_3030;
  localparam logic [95:0] REF = 96'h3132_3334_3536_3738_3930_A031;

  always @(posedge Clk) cyc <= cyc + 1;

  always_comb begin
    out_m = '0; out_l = '0; out_r = '0;
    for (int i = 0; i < 12; i++) begin
      out_m[95-8*i -: 8] = d_m[i];
      out_l[95-8*i -: 8] = d_l[i];
      out_r[95-8*i -: 8] = d_r[i];
    end
  end

  lcd_digit_encoder dut_m (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .VAL0(v[0]), .VAL1(v[1]), .VAL2(v[2]), .VAL3(v[3]), .VAL4(v[4]), .VAL5(v[5]),
    .YIMA_DATA1(d_m[0]), .YIMA_DATA2(d_m[1]), .YIMA_DATA3(d_m[2]), .YIMA_DATA4(d_m[3]),
    .YIMA_DATA5(d_m[4]), .YIMA_DATA6(d_m[5]), .YIMA_DATA7(d_m[6]), .YIMA_DATA8(d_m[7]),
    .YIMA_DATA9(d_m[8]), .YIMA_DATA10(d_m[9]), .YIMA_DATA11(d_m[10]), .YIMA_DATA12(d_m[11]),
    .Busy(busy_m), .Done(done_m)
  );

  lcd_digit_encoder #(.REFRESH_DIV(0), .LEAD_BLANK(1'b0)) dut_l (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .VAL0(v[0]), .VAL1(v[1]), .VAL2(v[2]), .VAL3(v[3]), .VAL4(v[4]), .VAL5(v[5]),
    .YIMA_DATA1(d_l[0]), .YIMA_DATA2(d_l[1]), .YIMA_DATA3(d_l[2]), .YIMA_DATA4(d_l[3]),
    .YIMA_DATA5(d_l[4]), .YIMA_DATA6(d_l[5]), .YIMA_DATA7(d_l[6]), .YIMA_DATA8(d_l[7]),
    .YIMA_DATA9(d_l[8]), .YIMA_DATA10(d_l[9]), .YIMA_DATA11(d_l[10]), .YIMA_DATA12(d_l[11]),
    .Busy(busy_l), .Done(done_l)
  );

  lcd_digit_encoder #(.REFRESH_DIV(64)) dut_r (
    .Clk(Clk), .Rst(rst_r), .Start(start_r),
    .VAL0(vr[0]), .VAL1(vr[1]), .VAL2(vr[2]), .VAL3(vr[3]), .VAL4(vr[4]), .VAL5(vr[5]),
    .YIMA_DATA1(d_r[0]), .YIMA_DATA2(d_r[1]), .YIMA_DATA3(d_r[2]), .YIMA_DATA4(d_r[3]),
    .YIMA_DATA5(d_r[4]), .YIMA_DATA6(d_r[5]), .YIMA_DATA7(d_r[6]), .YIMA_DATA8(d_r[7]),
    .YIMA_DATA9(d_r[8]), .YIMA_DATA10(d_r[9]), .YIMA_DATA11(d_r[10]), .YIMA_DATA12(d_r[11]),
    .Busy(busy_r), .Done(done_r)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Main-instance monitor: every Done pops one expected frame.
  always @(negedge Clk) begin
    if (!Rst && done_m) begin
      done_cnt_m++;
      if (q_m.size() == 0) begin
        check("main unexpected Done", {95'b0, done_m}, 96'b0);
      end else begin
        logic [95:0] e;
        int          ec;
        e  = q_m.pop_front();
        ec = qc_m.pop_front();
        check("main codes", out_m, e);
        if (ec >= 0) check("main Done cycle", cyc, ec);
      end
    end
  end

  // LEAD_BLANK=0 monitor.
  always @(negedge Clk) begin
    if (!Rst && done_l) begin
      if (q_l.size() == 0)
        check("lb0 unexpected Done", {95'b0, done_l}, 96'b0);
      else
        check("lb0 codes", out_l, q_l.pop_front());
    end
  end

  // Auto-refresh monitor: fixed inputs, Done every 64 cycles, outputs frozen between commits.
  always @(negedge Clk) begin
    if (!rst_r) begin
      if (done_r) begin
        check("refresh codes", out_r, REF);
        if (ref_last >= 0) check("refresh period", cyc - ref_last, 64);
        ref_last      = cyc;
        ref_cnt++;
        ref_committed = 1'b1;
        ref_prev      = out_r;
      end else if (ref_committed && out_r !== ref_prev) begin
        stable_viol++;
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge Clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((q_m.size() != 0 || q_l.size() != 0) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL drain %s: %0d frames still expected after %0d cycles", name, q_m.size() + q_l.size(), budget);
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic set_vals(input int a, input int b, input int c, input int d, input int e, input int f);
    v[0] = 7'(a); v[1] = 7'(b); v[2] = 7'(c); v[3] = 7'(d); v[4] = 7'(e); v[5] = 7'(f);
  endtask

  initial begin
    int t0;
    int dc0;
    Rst = 1'b1; rst_r = 1'b1; Start = 1'b0; start_r = 1'b0;
    set_vals(0, 0, 0, 0, 0, 0);
    vr[0] = 7'd12; vr[1] = 7'd34; vr[2] = 7'd56; vr[3] = 7'd78; vr[4] = 7'd90; vr[5] = 7'd1;

    // Reset held two cycles.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset codes main", out_m, ALL_BLANK);
    check("reset codes lb0", out_l, ALL_BLANK);
    check("reset codes refresh", out_r, ALL_BLANK);
    check("reset Busy", {93'b0, busy_m, busy_l, busy_r}, 96'b0);
    check("reset Done", {93'b0, done_m, done_l, done_r}, 96'b0);
    Rst = 1'b0; rst_r = 1'b0;
    @(negedge Clk);

    // Main vector, snapshot isolation and a request while busy.
    set_vals(42, 7, 0, 99, 10, 5);
    t0 = cyc;
    Start = 1'b1;
    q_m.push_back(E1); qc_m.push_back(t0 + 51); q_l.push_back(L1);
    @(negedge Clk);
    Start = 1'b0;
    check("Busy at T+1", {95'b0, busy_m}, 96'd1);
    goto(t0 + 5);
    v[0] = 7'd55;
    goto(t0 + 20);
    Start = 1'b1;
    q_m.push_back(E2); qc_m.push_back(-1); q_l.push_back(L2);
    @(negedge Clk);
    Start = 1'b0;
    goto(t0 + 50);
    check("Busy at T+50", {95'b0, busy_m}, 96'd1);
    check("Done low at T+50", {95'b0, done_m}, 96'd0);
    drain("pending", 200);

    // Values of 100 and above, single digits, exact boundaries.
    set_vals(100, 127, 9, 50, 1, 80);
    t0 = cyc;
    Start = 1'b1;
    q_m.push_back(E3); qc_m.push_back(t0 + 51); q_l.push_back(L3);
    @(negedge Clk);
    Start = 1'b0;
    goto(t0 + 51);
    check("Busy low at T+51", {95'b0, busy_m}, 96'd0);
    drain("overflow", 120);

    set_vals(19, 20, 64, 33, 5, 0);
    t0 = cyc;
    Start = 1'b1;
    q_m.push_back(E4); qc_m.push_back(t0 + 51); q_l.push_back(L4);
    @(negedge Clk);
    Start = 1'b0;
    drain("mixed", 120);

    // Reset in the middle of a conversion.
    set_vals(88, 88, 88, 88, 88, 88);
    t0 = cyc;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    goto(t0 + 30);
    Rst = 1'b1;
    dc0 = done_cnt_m;
    @(negedge Clk);
    check("abort codes", out_m, ALL_BLANK);
    check("abort Busy", {95'b0, busy_m}, 96'd0);
    check("abort Done", {95'b0, done_m}, 96'd0);
    Rst = 1'b0;
    repeat (80) @(negedge Clk);
    check("no Done after abort", done_cnt_m, dc0);

    repeat (100) @(negedge Clk);
    check("refresh Done count >= 5", {95'b0, (ref_cnt >= 5)}, 96'd1);
    check("refresh outputs stable", stable_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
